decode_queue: RTL and testbench

Registered, parametrised successor to the combinational RV32I control decoder. Accepts fetched instructions over a valid/ready handshake, decodes each into a full control bundle with illegal-instruction detection, and buffers decoded bundles in a DEPTH-entry FIFO feeding the execute stage. Optional RV32M decode is compiled in by macro. Sits between the fetch unit and the ID/EX boundary; `flush_i` supports branch/jump redirect.

---
 rtl/decode_queue_if.sv | 52 +++++
 rtl/decode_queue.sv | 266 ++++++++++++++++++++++++++
 tb/tb_decode_queue.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side signal bundle for decode_queue.
// slave is the queue's view; master is the fetch/EX (or bench) view.
interface decode_queue_if #(
    parameter int DEPTH   = 2,
    parameter int ALUOP_W = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               flush_i;
    logic               instr_valid_i;
    logic               instr_ready_o;
    logic [31:0]        instr_i;
    logic [31:0]        pc_i;
    logic               dec_valid_o;
    logic               dec_ready_i;
    logic [31:0]        pc_o;
    logic [31:0]        imm_o;
    logic [4:0]         src1_addr_o;
    logic [4:0]         src2_addr_o;
    logic [4:0]         rd_addr_o;
    logic               regwrite_o;
    logic               alusrc_o;
    logic               jal_o;
    logic               jalr_o;
    logic               memread_o;
    logic               memwrite_o;
    logic [ALUOP_W-1:0] aluop_o;
    logic [2:0]         width_select_o;
    logic [1:0]         memtoreg_o;
    logic [11:0]        csr_addr_o;
    logic [4:0]         zimm_o;
    logic               illegal_o;
    logic [CNT_W-1:0]   count_o;

    modport slave (
        input  flush_i, instr_valid_i, instr_i, pc_i, dec_ready_i,
        output instr_ready_o, dec_valid_o, pc_o, imm_o,
               src1_addr_o, src2_addr_o, rd_addr_o,
               regwrite_o, alusrc_o, jal_o, jalr_o, memread_o, memwrite_o,
               aluop_o, width_select_o, memtoreg_o, csr_addr_o, zimm_o,
               illegal_o, count_o
    );

    modport master (
        output flush_i, instr_valid_i, instr_i, pc_i, dec_ready_i,
        input  instr_ready_o, dec_valid_o, pc_o, imm_o,
               src1_addr_o, src2_addr_o, rd_addr_o,
               regwrite_o, alusrc_o, jal_o, jalr_o, memread_o, memwrite_o,
               aluop_o, width_select_o, memtoreg_o, csr_addr_o, zimm_o,
               illegal_o, count_o
    );
endinterface

// File: rtl/decode_queue.sv
// RV32I decoder feeding a DEPTH-entry FIFO of decoded control bundles.
// Define DECODE_RV32M_EN to accept the RV32M multiply/divide group.
module decode_queue #(
    parameter int DEPTH   = 2,
    parameter int ALUOP_W = 5
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    decode_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("decode_queue: DEPTH must be a power of two >= 2");
    end
`ifdef DECODE_RV32M_EN
    if (ALUOP_W < 5) begin : g_bad_aluop_w
        $error("decode_queue: RV32M decode needs ALUOP_W >= 5");
    end
`endif

    typedef struct packed {
        logic [31:0]        pc;
        logic [31:0]        imm;
        logic [4:0]         src1;
        logic [4:0]         src2;
        logic [4:0]         rd;
        logic               regwrite;
        logic               alusrc;
        logic               jal;
        logic               jalr;
        logic               memread;
        logic               memwrite;
        logic [ALUOP_W-1:0] aluop;
        logic [2:0]         width;
        logic [1:0]         memtoreg;
        logic [11:0]        csr;
        logic [4:0]         zimm;
        logic               illegal;
    } bundle_t;

    // Shared OP/OP-IMM arithmetic encoding; alt selects SUB / SRA.
    function automatic logic [3:0] alu_base(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? 4'd1 : 4'd0;
            3'b001:  return 4'd2;
            3'b010:  return 4'd3;
            3'b011:  return 4'd4;
            3'b100:  return 4'd5;
            3'b101:  return alt ? 4'd7 : 4'd6;
            3'b110:  return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rdf;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        ill;
    bundle_t     dec;

    assign instr  = bus.instr_i;
    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rdf    = instr[11:7];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec    = '0;
        ill    = 1'b0;
        dec.pc = bus.pc_i;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                dec.imm      = imm_u;
                dec.rd       = rdf;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
            end
            OP_JAL: begin
                dec.imm      = imm_j;
                dec.rd       = rdf;
                dec.regwrite = 1'b1;
                dec.jal      = 1'b1;
                dec.memtoreg = 2'b10;
            end
            OP_JALR: begin
                dec.imm      = imm_i;
                dec.src1     = rs1;
                dec.rd       = rdf;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.jalr     = 1'b1;
                dec.memtoreg = 2'b10;
                ill          = (f3 != 3'b000);
            end
            OP_BRANCH: begin
                dec.imm  = imm_b;
                dec.src1 = rs1;
                dec.src2 = rs2;
                case (f3)
                    3'b000:  dec.aluop = ALUOP_W'(10);
                    3'b001:  dec.aluop = ALUOP_W'(11);
                    3'b100:  dec.aluop = ALUOP_W'(12);
                    3'b101:  dec.aluop = ALUOP_W'(13);
                    3'b110:  dec.aluop = ALUOP_W'(14);
                    3'b111:  dec.aluop = ALUOP_W'(15);
                    default: ill = 1'b1;
                endcase
            end
            OP_LOAD: begin
                dec.imm      = imm_i;
                dec.src1     = rs1;
                dec.rd       = rdf;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.memread  = 1'b1;
                dec.memtoreg = 2'b01;
                case (f3)
                    3'b000:  dec.width = 3'b000;
                    3'b001:  dec.width = 3'b001;
                    3'b010:  dec.width = 3'b010;
                    3'b100:  dec.width = 3'b011;
                    3'b101:  dec.width = 3'b100;
                    default: ill = 1'b1;
                endcase
            end
            OP_STORE: begin
                dec.imm      = imm_s;
                dec.src1     = rs1;
                dec.src2     = rs2;
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                dec.width    = f3;
                ill          = (f3 > 3'b010);
            end
            OP_IMM: begin
                dec.src1     = rs1;
                dec.rd       = rdf;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.aluop    = ALUOP_W'(alu_base(f3, f3 == 3'b101 && f7[5]));
                if (f3 == 3'b001 || f3 == 3'b101) dec.imm = {27'b0, rs2};
                else                              dec.imm = imm_i;
                if (f3 == 3'b001) ill = (f7 != 7'b0000000);
                if (f3 == 3'b101) ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            end
            OP_OP: begin
                dec.src1     = rs1;
                dec.src2     = rs2;
                dec.rd       = rdf;
                dec.regwrite = 1'b1;
                dec.aluop    = ALUOP_W'(alu_base(f3, f7[5]));
                ill = !((f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
`ifdef DECODE_RV32M_EN
                if (f7 == 7'b0000001) begin
                    dec.aluop = ALUOP_W'({2'b10, f3});
                    ill       = 1'b0;
                end
`endif
            end
            OP_FENCE: ;
            OP_SYSTEM: begin
                dec.imm      = imm_i;
                dec.src1     = rs1;
                dec.rd       = rdf;
                dec.regwrite = (f3 != 3'b000);
                dec.csr      = instr[31:20];
                dec.zimm     = rs1;
            end
            default: ill = 1'b1;
        endcase
        if (instr[1:0] != 2'b11) ill = 1'b1;
        // Illegal entries keep their fields for trap reporting but cause no side effects.
        if (ill) begin
            dec.regwrite = 1'b0;
            dec.memread  = 1'b0;
            dec.memwrite = 1'b0;
            dec.jal      = 1'b0;
            dec.jalr     = 1'b0;
        end
        dec.illegal = ill;
    end

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    bundle_t          mem [DEPTH];
    bundle_t          head;
    logic             ready, valid, push, pop;

    assign ready = count < CNT_W'(DEPTH);
    assign valid = count != '0;
    assign push  = bus.instr_valid_i & ready & ~bus.flush_i;
    assign pop   = valid & bus.dec_ready_i & ~bus.flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: outputs are masked whenever the queue is empty.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= dec;
    end

    assign head = valid ? mem[rd_ptr] : '0;

    assign bus.instr_ready_o  = ready;
    assign bus.dec_valid_o    = valid;
    assign bus.count_o        = count;
    assign bus.pc_o           = head.pc;
    assign bus.imm_o          = head.imm;
    assign bus.src1_addr_o    = head.src1;
    assign bus.src2_addr_o    = head.src2;
    assign bus.rd_addr_o      = head.rd;
    assign bus.regwrite_o     = head.regwrite;
    assign bus.alusrc_o       = head.alusrc;
    assign bus.jal_o          = head.jal;
    assign bus.jalr_o         = head.jalr;
    assign bus.memread_o      = head.memread;
    assign bus.memwrite_o     = head.memwrite;
    assign bus.aluop_o        = head.aluop;
    assign bus.width_select_o = head.width;
    assign bus.memtoreg_o     = head.memtoreg;
    assign bus.csr_addr_o     = head.csr;
    assign bus.zimm_o         = head.zimm;
    assign bus.illegal_o      = head.illegal;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: a decode vector table plus handshake,
// flush and asynchronous-reset sequences.
module tb_decode_queue;
    localparam int DEPTH   = 4;
    localparam int ALUOP_W = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    decode_queue_if #(.DEPTH(DEPTH), .ALUOP_W(ALUOP_W)) bus ();

    decode_queue #(.DEPTH(DEPTH), .ALUOP_W(ALUOP_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // ctl = {regwrite, alusrc, jal, jalr, memread, memwrite}
    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [4:0]  s1, s2, rd;
        logic [5:0]  ctl;
        logic [4:0]  aluop;
        logic [2:0]  width;
        logic [1:0]  m2r;
        logic [11:0] csr;
        logic [4:0]  zimm;
        logic        ill;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] imm,
                                input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] rd,
                                input logic [5:0] ctl, input logic [4:0] aluop,
                                input logic [2:0] width, input logic [1:0] m2r,
                                input logic [11:0] csr, input logic [4:0] zimm, input logic ill);
        vec_t v;
        v.instr = instr; v.imm = imm; v.s1 = s1; v.s2 = s2; v.rd = rd;
        v.ctl = ctl; v.aluop = aluop; v.width = width; v.m2r = m2r;
        v.csr = csr; v.zimm = zimm; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_only(input logic [31:0] instr, input logic [31:0] pc);
        @(negedge clk);
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = instr;
        bus.pc_i          = pc;
        bus.dec_ready_i   = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.instr_valid_i = 1'b0;
        bus.dec_ready_i   = 1'b0;
        bus.flush_i       = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
        bus.instr_valid_i = 1'b0;
        bus.dec_ready_i   = 1'b1;
        repeat (DEPTH) @(negedge clk);
        bus.dec_ready_i   = 1'b0;
    endtask

    initial begin
        logic [5:0] ctl_act;
        string      n;

        bus.flush_i       = 1'b0;
        bus.instr_valid_i = 1'b0;
        bus.instr_i       = '0;
        bus.pc_i          = '0;
        bus.dec_ready_i   = 1'b0;

        vt.push_back(mk(32'hFFF00293, 32'hFFFFFFFF, 0, 0, 5, 6'b110000, 0,  3'b000, 2'b00, 12'h000, 0, 0)); // addi
        vt.push_back(mk(32'h00415083, 32'h00000004, 2, 0, 1, 6'b110010, 0,  3'b100, 2'b01, 12'h000, 0, 0)); // lhu
        vt.push_back(mk(32'h0020A423, 32'h00000008, 1, 2, 0, 6'b010001, 0,  3'b010, 2'b00, 12'h000, 0, 0)); // sw
        vt.push_back(mk(32'h0020B423, 32'h00000008, 1, 2, 0, 6'b010000, 0,  3'b011, 2'b00, 12'h000, 0, 1)); // store f3=011
`ifdef DECODE_RV32M_EN
        vt.push_back(mk(32'h022081B3, 32'h00000000, 1, 2, 3, 6'b100000, 16, 3'b000, 2'b00, 12'h000, 0, 0)); // mul
`else
        vt.push_back(mk(32'h022081B3, 32'h00000000, 1, 2, 3, 6'b000000, 0,  3'b000, 2'b00, 12'h000, 0, 1)); // mul
`endif
        vt.push_back(mk(32'h402081B3, 32'h00000000, 1, 2, 3, 6'b100000, 1,  3'b000, 2'b00, 12'h000, 0, 0)); // sub
        vt.push_back(mk(32'h00208463, 32'h00000008, 1, 2, 0, 6'b000000, 10, 3'b000, 2'b00, 12'h000, 0, 0)); // beq
        vt.push_back(mk(32'h123453B7, 32'h12345000, 0, 0, 7, 6'b110000, 0,  3'b000, 2'b00, 12'h000, 0, 0)); // lui
        vt.push_back(mk(32'h010000EF, 32'h00000010, 0, 0, 1, 6'b101000, 0,  3'b000, 2'b10, 12'h000, 0, 0)); // jal
        vt.push_back(mk(32'h4032D213, 32'h00000003, 5, 0, 4, 6'b110000, 7,  3'b000, 2'b00, 12'h000, 0, 0)); // srai
        vt.push_back(mk(32'h02109093, 32'h00000001, 1, 0, 1, 6'b010000, 2,  3'b000, 2'b00, 12'h000, 0, 1)); // slli bad f7
        vt.push_back(mk(32'h00000000, 32'h00000000, 0, 0, 0, 6'b000000, 0,  3'b000, 2'b00, 12'h000, 0, 1)); // low bits 00
        vt.push_back(mk(32'h300110F3, 32'h00000300, 2, 0, 1, 6'b100000, 0,  3'b000, 2'b00, 12'h300, 2, 0)); // csrrw
        vt.push_back(mk(32'h00009067, 32'h00000000, 1, 0, 0, 6'b010000, 0,  3'b000, 2'b10, 12'h000, 0, 1)); // jalr f3=001
        vt.push_back(mk(32'h0000000F, 32'h00000000, 0, 0, 0, 6'b000000, 0,  3'b000, 2'b00, 12'h000, 0, 0)); // fence

        // Reset state
        #12;
        chk("rst.dec_valid", 32'(bus.dec_valid_o), 32'd0);
        chk("rst.ready", 32'(bus.instr_ready_o), 32'd1);
        chk("rst.count", 32'(bus.count_o), 32'd0);
        chk("rst.pc", bus.pc_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First-transaction latency with EX ready
        @(negedge clk);
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = 32'hFFF00293;
        bus.pc_i          = 32'h100;
        bus.dec_ready_i   = 1'b1;
        @(posedge clk); #1;
        chk("lat.valid", 32'(bus.dec_valid_o), 32'd1);
        chk("lat.pc", bus.pc_o, 32'h100);
        chk("lat.imm", bus.imm_o, 32'hFFFFFFFF);
        chk("lat.rd", 32'(bus.rd_addr_o), 32'd5);
        @(negedge clk);
        bus.instr_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("lat.valid_after", 32'(bus.dec_valid_o), 32'd0);
        idle();

        // Decode table
        for (int i = 0; i < vt.size(); i++) begin
            push_only(vt[i].instr, 32'h1000 + 32'(i * 4));
            @(negedge clk);
            bus.instr_valid_i = 1'b0;
            bus.dec_ready_i   = 1'b1;
            #1;
            ctl_act = {bus.regwrite_o, bus.alusrc_o, bus.jal_o, bus.jalr_o,
                       bus.memread_o, bus.memwrite_o};
            n = $sformatf("v%0d_%h", i, vt[i].instr);
            chk({n, ".valid"}, 32'(bus.dec_valid_o), 32'd1);
            chk({n, ".pc"}, bus.pc_o, 32'h1000 + 32'(i * 4));
            chk({n, ".imm"}, bus.imm_o, vt[i].imm);
            chk({n, ".regs"}, {17'b0, bus.src1_addr_o, bus.src2_addr_o, bus.rd_addr_o},
                {17'b0, vt[i].s1, vt[i].s2, vt[i].rd});
            chk({n, ".ctl"}, 32'(ctl_act), 32'(vt[i].ctl));
            chk({n, ".aluop"}, 32'(bus.aluop_o), 32'(vt[i].aluop));
            chk({n, ".width"}, 32'(bus.width_select_o), 32'(vt[i].width));
            chk({n, ".memtoreg"}, 32'(bus.memtoreg_o), 32'(vt[i].m2r));
            chk({n, ".csr_zimm"}, {15'b0, bus.csr_addr_o, bus.zimm_o}, {15'b0, vt[i].csr, vt[i].zimm});
            chk({n, ".illegal"}, 32'(bus.illegal_o), 32'(vt[i].ill));
        end
        idle();

        // Fill, refused push while full with pop, then ordered drain
        for (int i = 0; i < DEPTH; i++) push_only(32'h00000013, 32'h200 + 32'(i * 4));
        @(negedge clk);
        bus.instr_valid_i = 1'b0;
        #1;
        chk("full.count", 32'(bus.count_o), DEPTH);
        chk("full.ready", 32'(bus.instr_ready_o), 32'd0);
        @(negedge clk);
        bus.instr_valid_i = 1'b1;
        bus.pc_i          = 32'h999;
        bus.dec_ready_i   = 1'b1;
        #1;
        chk("fullpop.ready", 32'(bus.instr_ready_o), 32'd0);
        chk("fullpop.pc", bus.pc_o, 32'h200);
        @(negedge clk);
        bus.instr_valid_i = 1'b0;
        #1;
        chk("fullpop.count", 32'(bus.count_o), 32'd3);
        for (int k = 1; k < DEPTH; k++) begin
            chk($sformatf("drain%0d.pc", k), bus.pc_o, 32'h200 + 32'(k * 4));
            @(negedge clk); #1;
        end
        chk("drain.count", 32'(bus.count_o), 32'd0);
        chk("drain.valid", 32'(bus.dec_valid_o), 32'd0);
        idle();

        // Simultaneous push and pop keeps count
        push_only(32'h00000013, 32'h500);
        @(negedge clk);
        bus.pc_i        = 32'h504;
        bus.dec_ready_i = 1'b1;
        #1;
        chk("pp.pc_before", bus.pc_o, 32'h500);
        idle();
        #1;
        chk("pp.count", 32'(bus.count_o), 32'd1);
        chk("pp.pc_after", bus.pc_o, 32'h504);
        drain();

        // Flush with three queued and a same-cycle push
        for (int i = 0; i < 3; i++) push_only(32'h00000013, 32'h300 + 32'(i * 4));
        @(negedge clk);
        bus.instr_valid_i = 1'b1;
        bus.pc_i          = 32'h3FF;
        bus.flush_i       = 1'b1;
        #1;
        chk("flush.ready_pre", 32'(bus.instr_ready_o), 32'd1);
        chk("flush.count_pre", 32'(bus.count_o), 32'd3);
        idle();
        #1;
        chk("flush.count", 32'(bus.count_o), 32'd0);
        chk("flush.valid", 32'(bus.dec_valid_o), 32'd0);
        chk("flush.pc", bus.pc_o, 32'd0);
        idle();
        #1;
        chk("flush.valid_later", 32'(bus.dec_valid_o), 32'd0);
        push_only(32'h00000013, 32'h400);
        idle();
        #1;
        chk("flush.resume_pc", bus.pc_o, 32'h400);
        chk("flush.resume_count", 32'(bus.count_o), 32'd1);
        drain();

        // Asynchronous reset with a full queue
        for (int i = 0; i < DEPTH; i++) push_only(32'hFFF00293, 32'h600 + 32'(i * 4));
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", 32'(bus.dec_valid_o), 32'd0);
        chk("arst.ready", 32'(bus.instr_ready_o), 32'd1);
        chk("arst.count", 32'(bus.count_o), 32'd0);
        chk("arst.pc", bus.pc_o, 32'd0);
        chk("arst.imm", bus.imm_o, 32'd0);
        chk("arst.regwrite", 32'(bus.regwrite_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_only(32'h123453B7, 32'h700);
        idle();
        #1;
        chk("arst.resume_valid", 32'(bus.dec_valid_o), 32'd1);
        chk("arst.resume_pc", bus.pc_o, 32'h700);
        chk("arst.resume_imm", bus.imm_o, 32'h12345000);
        chk("arst.resume_count", 32'(bus.count_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
